// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle unsigned shift-add multiplier that borrows the
// shared combinational alu for its additions. Operands enter on an in_valid /
// in_ready handshake; the low DATA_WIDTH bits of the product and an exact
// overflow flag leave on an out_valid / out_ready handshake.
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. in_ready is high only in IDLE, out_valid only in DONE;
// in_valid is ignored in any other state, and out_valid/out_result/out_overflow
// hold steady while out_ready is low.
module alu_mul_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_overflow,
    output logic [DATA_WIDTH-1:0] alu_A,
    output logic [DATA_WIDTH-1:0] alu_B,
    output logic [2:0]            alu_ALUop,
    input  logic [DATA_WIDTH-1:0] alu_Result,
    input  logic                  alu_CarryOut
);

    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_NONE = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0] mplier;
    logic [CW-1:0]         cnt;
    logic                  ovf;

    logic accept;
    logic more_bits;
    logic last_iter;

    assign accept    = (state == IDLE) && in_valid;
    // Multiplier bits still waiting to be consumed after this iteration.
    assign more_bits = (mplier >> 1) != '0;
    assign last_iter = !more_bits || (cnt == CW'(DATA_WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Shift-add datapath. Overflow is exact: it is set either by a carry out of
    // an accumulate, or by a set multiplicand bit being shifted out while
    // multiplier bits remain that would still have needed it.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= in_a;
            mplier <= in_b;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else if (state == RUN) begin
            if (mplier[0]) begin
                acc <= alu_Result;
            end
            ovf    <= ovf | (mplier[0] & alu_CarryOut) | (mcand[DATA_WIDTH-1] & more_bits);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

    // Output decode; the alu is only claimed while iterating.
    always_comb begin
        in_ready     = (state == IDLE);
        out_valid    = (state == DONE);
        out_result   = acc;
        out_overflow = ovf;
        alu_A        = '0;
        alu_B        = '0;
        alu_ALUop    = ALU_NONE;
        if (state == RUN) begin
            alu_A     = acc;
            alu_B     = mcand;
            alu_ALUop = ALU_ADD;
        end
    end

endmodule
